// File: rtl/demux_pkg.sv
// Shared definitions for the parametrised 1:N round-robin / explicit-select demux.
package demux_pkg;

  localparam int MODE_RR  = 0;
  localparam int MODE_SEL = 1;

  // Lane-select width: ceil(log2(n)), never narrower than one bit.
  function automatic int sel_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One output lane: a single-word holding register with valid/ready handshake.
module demux_lane_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              free
);

  logic              valid_reg;
  logic              valid_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;

  // A draining lane counts as free so it can reload without a bubble.
  assign free      = !valid_reg || ready_out;
  assign valid_out = valid_reg;
  assign data_out  = data_reg;

  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (load) begin
      valid_next = 1'b1;
      data_next  = load_data;
    end else if (valid_reg && ready_out) begin
      // Data is left in place after a drain; only the valid flag drops.
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

endmodule

// File: rtl/demux1an_param_rr.sv
// 1:NUM_OUT stream demux with per-lane holding registers; lanes chosen round-robin
// (MODE_RR) or by sel_in (MODE_SEL).
module demux1an_param_rr
  import demux_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NUM_OUT = 2,
  parameter  int MODE    = MODE_RR,
  localparam int SEL_W   = sel_width(NUM_OUT)
) (
  input  logic                      clk_2f,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [SEL_W-1:0]          sel_in,
  output logic                      ready_in,
  output logic [NUM_OUT-1:0]        valid_out,
  output logic [NUM_OUT*DATA_W-1:0] data_out,
  input  logic [NUM_OUT-1:0]        ready_out,
  output logic [SEL_W-1:0]          ptr_out,
  output logic                      err_sel
);

  localparam logic [SEL_W:0]   LANE_LIMIT = (SEL_W+1)'(NUM_OUT);
  localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   ptr_reg;
  logic [SEL_W-1:0]   ptr_next;
  logic               err_reg;
  logic               err_next;
  logic [SEL_W-1:0]   target;
  logic               target_ok;
  logic               target_free;
  logic               accept;
  logic [NUM_OUT-1:0] lane_hit;
  logic [NUM_OUT-1:0] load;
  logic [NUM_OUT-1:0] free;

  assign target      = (MODE == MODE_SEL) ? sel_in : ptr_reg;
  // Extra MSB so the range test stays valid when NUM_OUT is a power of two.
  assign target_ok   = ({1'b0, target} < LANE_LIMIT);
  assign target_free = |(lane_hit & free);
  assign ready_in    = !reset && target_ok && target_free;
  assign accept      = valid_in && ready_in;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_lane
    assign lane_hit[gi] = (target == SEL_W'(gi));
    assign load[gi]     = accept && lane_hit[gi];

    demux_lane_reg #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk_2f   (clk_2f),
      .reset    (reset),
      .load     (load[gi]),
      .load_data(data_in),
      .ready_out(ready_out[gi]),
      .valid_out(valid_out[gi]),
      .data_out (data_out[gi*DATA_W +: DATA_W]),
      .free     (free[gi])
    );
  end

  always_comb begin
    ptr_next = ptr_reg;
    err_next = 1'b0;
    if (MODE == MODE_SEL) begin
      ptr_next = '0;
      err_next = valid_in && !target_ok;
    end else if (accept) begin
      // Pointer only moves on an accepted word, so a stall never skips a lane.
      ptr_next = (ptr_reg == PTR_LAST) ? '0 : ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      ptr_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      ptr_reg <= ptr_next;
      err_reg <= err_next;
    end
  end

  assign ptr_out = ptr_reg;
  assign err_sel = err_reg;

endmodule

// File: tb/tb_demux1an_param_rr.sv
// Bench for demux1an_param_rr: three instances (2-lane RR, 3-lane RR, 3-lane explicit)
// with a per-lane scoreboard checked whenever a lane hands a word downstream.
module tb_demux1an_param_rr;

  logic clk_2f = 1'b0;
  logic reset  = 1'b1;
  always #5 clk_2f = ~clk_2f;

  // Instance A: NUM_OUT=2, round-robin
  logic        a_valid_in = 1'b0;
  logic [7:0]  a_data_in = '0;
  logic [0:0]  a_sel_in = '0;
  logic        a_ready_in;
  logic [1:0]  a_valid_out;
  logic [15:0] a_data_out;
  logic [1:0]  a_ready_out = '0;
  logic [0:0]  a_ptr_out;
  logic        a_err_sel;
  // Instance B: NUM_OUT=3, round-robin
  logic        b_valid_in = 1'b0;
  logic [7:0]  b_data_in = '0;
  logic [1:0]  b_sel_in = '0;
  logic        b_ready_in;
  logic [2:0]  b_valid_out;
  logic [23:0] b_data_out;
  logic [2:0]  b_ready_out = 3'b111;
  logic [1:0]  b_ptr_out;
  logic        b_err_sel;
  // Instance C: NUM_OUT=3, explicit select
  logic        c_valid_in = 1'b0;
  logic [7:0]  c_data_in = '0;
  logic [1:0]  c_sel_in = '0;
  logic        c_ready_in;
  logic [2:0]  c_valid_out;
  logic [23:0] c_data_out;
  logic [2:0]  c_ready_out = '0;
  logic [1:0]  c_ptr_out;
  logic        c_err_sel;

  demux1an_param_rr #(.DATA_W(8), .NUM_OUT(2), .MODE(0)) u_a (
    .clk_2f(clk_2f), .reset(reset), .valid_in(a_valid_in), .data_in(a_data_in),
    .sel_in(a_sel_in), .ready_in(a_ready_in), .valid_out(a_valid_out),
    .data_out(a_data_out), .ready_out(a_ready_out), .ptr_out(a_ptr_out), .err_sel(a_err_sel));

  demux1an_param_rr #(.DATA_W(8), .NUM_OUT(3), .MODE(0)) u_b (
    .clk_2f(clk_2f), .reset(reset), .valid_in(b_valid_in), .data_in(b_data_in),
    .sel_in(b_sel_in), .ready_in(b_ready_in), .valid_out(b_valid_out),
    .data_out(b_data_out), .ready_out(b_ready_out), .ptr_out(b_ptr_out), .err_sel(b_err_sel));

  demux1an_param_rr #(.DATA_W(8), .NUM_OUT(3), .MODE(1)) u_c (
    .clk_2f(clk_2f), .reset(reset), .valid_in(c_valid_in), .data_in(c_data_in),
    .sel_in(c_sel_in), .ready_in(c_ready_in), .valid_out(c_valid_out),
    .data_out(c_data_out), .ready_out(c_ready_out), .ptr_out(c_ptr_out), .err_sel(c_err_sel));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         inst;
    int         lane;
    logic [7:0] data;
  } sb_t;
  sb_t sb_q[$];
  int  mptr_a = 0;
  int  mptr_b = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic sb_push(input int inst, input int lane, input logic [7:0] data);
    sb_t e;
    e.inst = inst;
    e.lane = lane;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_check(input int inst, input int lane, input logic [7:0] act);
    int idx;
    idx = -1;
    for (int i = 0; i < sb_q.size(); i++)
      if (idx < 0 && sb_q[i].inst == inst && sb_q[i].lane == lane) idx = i;
    n_tests++;
    if (idx < 0) begin
      n_fail++;
      $display("FAIL sb_u%0d_lane%0d: got word %02h, required no word", inst, lane, act);
    end else begin
      if (sb_q[idx].data !== act) begin
        n_fail++;
        $display("FAIL sb_u%0d_lane%0d: got %02h, required %02h", inst, lane, act, sb_q[idx].data);
      end else begin
        $display("[TB] xfer u%0d lane%0d data %02h", inst, lane, act);
      end
      sb_q.delete(idx);
    end
  endtask

  // Mid-cycle monitor: retire handed-off words, then record newly accepted words
  // into the lane the reference model predicts.
  always @(negedge clk_2f) begin
    if (reset) begin
      sb_q.delete();
      mptr_a = 0;
      mptr_b = 0;
    end else begin
      for (int k = 0; k < 2; k++)
        if (a_valid_out[k] && a_ready_out[k]) sb_pop_check(0, k, a_data_out[k*8 +: 8]);
      for (int k = 0; k < 3; k++) begin
        if (b_valid_out[k] && b_ready_out[k]) sb_pop_check(1, k, b_data_out[k*8 +: 8]);
        if (c_valid_out[k] && c_ready_out[k]) sb_pop_check(2, k, c_data_out[k*8 +: 8]);
      end
      check("a_ptr_model", 32'(a_ptr_out), 32'(mptr_a));
      check("b_ptr_model", 32'(b_ptr_out), 32'(mptr_b));
      if (a_valid_in && a_ready_in) begin
        sb_push(0, mptr_a, a_data_in);
        mptr_a = (mptr_a == 1) ? 0 : mptr_a + 1;
      end
      if (b_valid_in && b_ready_in) begin
        sb_push(1, mptr_b, b_data_in);
        mptr_b = (mptr_b == 2) ? 0 : mptr_b + 1;
      end
      if (c_valid_in && c_ready_in) sb_push(2, int'(c_sel_in), c_data_in);
    end
  end

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         lane;
    int         ptr;
  } rr_vec_t;
  rr_vec_t rr_vec[6];

  initial begin
    rr_vec[0] = '{8'h10, 0, 0};
    rr_vec[1] = '{8'h11, 1, 1};
    rr_vec[2] = '{8'h12, 2, 2};
    rr_vec[3] = '{8'h13, 0, 0};
    rr_vec[4] = '{8'h14, 1, 1};
    rr_vec[5] = '{8'h15, 2, 2};

    // Reset held two cycles with a word pending
    a_valid_in  = 1'b1;
    a_data_in   = 8'hFF;
    a_ready_out = 2'b11;
    repeat (2) @(posedge clk_2f);
    #1;
    check("rst_valid_out", 32'(a_valid_out), 32'h0);
    check("rst_data_out", 32'(a_data_out), 32'h0);
    check("rst_ptr_out", 32'(a_ptr_out), 32'h0);
    check("rst_ready_in", 32'(a_ready_in), 32'h0);
    check("rst_err_sel", 32'(c_err_sel), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_ready_in", 32'(a_ready_in), 32'h1);
    tick();
    check("post_rst_valid", 32'(a_valid_out), 32'h1);
    check("post_rst_lane0", 32'(a_data_out[7:0]), 32'hFF);
    a_valid_in = 1'b0;
    tick();

    // Round-robin wrap over three lanes, table-driven
    for (int i = 0; i < 6; i++) begin
      b_valid_in = 1'b1;
      b_data_in  = rr_vec[i].data;
      #1;
      check($sformatf("rr%0d_ptr", i), 32'(b_ptr_out), 32'(rr_vec[i].ptr));
      check($sformatf("rr%0d_ready", i), 32'(b_ready_in), 32'h1);
      tick();
      check($sformatf("rr%0d_valid", i), 32'(b_valid_out), 32'(1 << rr_vec[i].lane));
      check($sformatf("rr%0d_data", i), 32'(b_data_out[rr_vec[i].lane*8 +: 8]), 32'(rr_vec[i].data));
    end
    b_valid_in = 1'b0;
    #1;
    check("rr_ptr_wrapped", 32'(b_ptr_out), 32'h0);
    tick();

    // Explicit select, then an out-of-range select
    c_ready_out = 3'b000;
    c_valid_in  = 1'b1;
    c_sel_in    = 2'd2;
    c_data_in   = 8'h33;
    #1;
    check("sel2_ready", 32'(c_ready_in), 32'h1);
    tick();
    check("sel2_valid", 32'(c_valid_out), 32'h4);
    check("sel2_data", 32'(c_data_out[23:16]), 32'h33);
    check("sel2_ptr_held", 32'(c_ptr_out), 32'h0);
    check("sel2_err", 32'(c_err_sel), 32'h0);
    c_sel_in  = 2'd3;
    c_data_in = 8'h44;
    #1;
    check("sel3_ready", 32'(c_ready_in), 32'h0);
    tick();
    check("sel3_err_pulse", 32'(c_err_sel), 32'h1);
    check("sel3_valid", 32'(c_valid_out), 32'h4);
    check("sel3_data", 32'(c_data_out), 32'h330000);
    c_valid_in = 1'b0;
    c_sel_in   = 2'd0;
    tick();
    check("sel3_err_cleared", 32'(c_err_sel), 32'h0);
    c_ready_out = 3'b100;
    tick();
    check("sel_drained", 32'(c_valid_out), 32'h0);
    c_ready_out = 3'b000;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty_mid: got %0d pending, required 0", sb_q.size());
    end

    // Backpressure on the 2-lane instance from a clean state
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    a_ready_out = 2'b00;
    a_valid_in  = 1'b1;
    a_data_in   = 8'hA1;
    #1;
    check("bp_a1_ready", 32'(a_ready_in), 32'h1);
    tick();
    a_data_in = 8'hB2;
    #1;
    check("bp_b2_ready", 32'(a_ready_in), 32'h1);
    tick();
    a_data_in = 8'hC3;
    #1;
    check("bp_c3_stall", 32'(a_ready_in), 32'h0);
    check("bp_c3_ptr", 32'(a_ptr_out), 32'h0);
    check("bp_full_valid", 32'(a_valid_out), 32'h3);
    check("bp_full_data", 32'(a_data_out), 32'hB2A1);
    tick();
    check("bp_still_stall", 32'(a_ready_in), 32'h0);
    check("bp_still_data", 32'(a_data_out), 32'hB2A1);
    a_ready_out = 2'b01;
    #1;
    check("bp_release_ready", 32'(a_ready_in), 32'h1);
    tick();
    check("bp_replace_valid", 32'(a_valid_out), 32'h3);
    check("bp_replace_data", 32'(a_data_out), 32'hB2C3);
    a_valid_in  = 1'b0;
    a_ready_out = 2'b10;
    tick();
    check("drain1_valid", 32'(a_valid_out), 32'h1);
    check("drain1_data_held", 32'(a_data_out[15:8]), 32'hB2);
    a_ready_out = 2'b00;
    a_valid_in  = 1'b1;
    a_data_in   = 8'h77;
    tick();
    check("fill1_valid", 32'(a_valid_out), 32'h3);
    check("fill1_ptr", 32'(a_ptr_out), 32'h0);

    // Drain and reload the same lane in one cycle
    a_ready_out = 2'b01;
    a_data_in   = 8'h5A;
    #1;
    check("dr_ready", 32'(a_ready_in), 32'h1);
    tick();
    check("dr_valid", 32'(a_valid_out), 32'h3);
    check("dr_data", 32'(a_data_out[7:0]), 32'h5A);
    a_valid_in = 1'b0;
    tick();
    check("dr_drained", 32'(a_valid_out), 32'h2);

    // Reset while both lanes are full and stalled
    a_ready_out = 2'b10;
    a_valid_in  = 1'b1;
    a_data_in   = 8'h99;
    tick();
    a_ready_out = 2'b00;
    a_data_in   = 8'hAA;
    tick();
    check("mid_full_valid", 32'(a_valid_out), 32'h3);
    check("mid_full_data", 32'(a_data_out), 32'h99AA);
    reset     = 1'b1;
    a_data_in = 8'hBB;
    #1;
    check("mid_rst_ready", 32'(a_ready_in), 32'h0);
    tick();
    check("mid_rst_valid", 32'(a_valid_out), 32'h0);
    check("mid_rst_ptr", 32'(a_ptr_out), 32'h0);
    check("mid_rst_data", 32'(a_data_out), 32'h0);
    reset       = 1'b0;
    a_valid_in  = 1'b0;
    a_ready_out = 2'b11;
    repeat (3) tick();
    check("mid_rst_no_present", 32'(a_valid_out), 32'h0);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty_end: got %0d pending, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1an_param_rr.md
Name: demux1aN_param_rr

Overview:
- Parametrised successor to the fixed 1:2 data demux in the Rx path.
- Steers a DATA_W-bit valid-qualified stream from the clk_2f domain to NUM_OUT output lanes.
- Lane choice is round-robin (ping-pong generalised) or explicit select.
- Each lane has a registered holding stage with valid/ready backpressure, so downstream lanes may stall without losing words.

Parameters:
- DATA_W, 8, width of each data word (>=1).
- NUM_OUT, 2, number of output lanes (>=2, need not be a power of 2).
- MODE, 0, 0 = round-robin steering, 1 = explicit steering via sel_in.
- SEL_W, derived localparam = max(1, clog2(NUM_OUT)), not overridable.

Ports:
- clk_2f  in  1  single clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  input word valid.
- data_in  in  DATA_W  input word.
- sel_in  in  SEL_W  target lane; used only when MODE=1.
- ready_in  out  1  block accepts data_in this cycle (combinational).
- valid_out  out  NUM_OUT  per-lane output valid (registered).
- data_out  out  NUM_OUT*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W] (registered).
- ready_out  in  NUM_OUT  per-lane downstream ready.
- ptr_out  out  SEL_W  current round-robin pointer (registered; held at 0 when MODE=1).
- err_sel  out  1  registered 1-cycle pulse on an out-of-range select attempt.

Behaviour:
- Reset, synchronous, active-high, sampled at posedge clk_2f: valid_out=0, data_out=0, ptr_out=0, err_sel=0. Reset mid-operation discards every held word with no partial drain. ready_in is 0 while reset=1.
- Target lane t: MODE=0 gives t=ptr_out; MODE=1 gives t=sel_in.
- Lane k is free when (!valid_out[k] || ready_out[k]). A draining lane can reload in the same cycle.
- ready_in = !reset && (t < NUM_OUT) && free[t]. It depends combinationally on valid_out, ready_out, sel_in and ptr.
- Accept = valid_in && ready_in. On accept, next cycle: data_out[t]=data_in and valid_out[t]=1. Latency is exactly 1 cycle, input to lane.
- Drain: valid_out[k] && ready_out[k] with no reload in the same cycle gives valid_out[k]=0 next cycle. data_out[k] is held and not cleared.
- Non-accepted lanes hold valid_out and data_out unchanged while ready_out[k]=0. No overwrite of a valid, un-drained word is ever permitted.
- Round-robin (MODE=0):
  - ptr advances only on accept: ptr = (ptr==NUM_OUT-1) ? 0 : ptr+1.
  - On stall (valid_in=1, ready_in=0), ptr holds. No lane skipping, so strict order is preserved: word n goes to lane n mod NUM_OUT.
- Explicit (MODE=1):
  - If sel_in >= NUM_OUT and valid_in=1: ready_in=0 and err_sel=1 on the next cycle; the word is not accepted.
  - err_sel is a single-cycle pulse per offending cycle.
- Upstream protocol: a source holding valid_in=1 with ready_in=0 keeps data_in and sel_in stable. The block does not check this.
- valid_in=0: no state change except drains.
- Simultaneous accept into lane t and drain of lane t: the new word loads and valid_out[t] stays 1.
- All lanes full and none ready: ready_in=0 and the stream stalls indefinitely with no data loss.

Decomposition:
- Shared package demux_pkg: MODE_RR=0, MODE_SEL=1 constants; a clog2-style SEL_W helper function.
- Sub-module demux_lane_reg (DATA_W), instantiated NUM_OUT times in a generate loop:
  - inputs clk_2f, reset, load, load_data, ready_out;
  - outputs valid_out, data_out, free.
- Top level holds the pointer counter, target decode, ready_in logic and err_sel register.

Test Plan:
- Reset: reset=1 for 2 cycles with valid_in=1, data_in=8'hFF -> valid_out=0, data_out=0, ptr_out=0, ready_in=0. After release with all ready_out=1: 8'hFF lands in lane 0 one cycle later.
- Round-robin wrap, NUM_OUT=3, MODE=0, ready_out=3'b111: stream 8'h10..8'h15 -> lanes 0,1,2,0,1,2 receive 10,11,12,13,14,15. ptr_out sequence 0,1,2,0,1,2,0.
- Backpressure, NUM_OUT=2: ready_out=2'b00, send A1, B2, then C3 ->
  - A1 in lane 0, B2 in lane 1;
  - C3 stalls with ready_in=0 and ptr=0;
  - raising ready_out[0] makes C3 replace A1 in the same cycle, with valid_out[0] staying 1;
  - lane 1 keeps B2 held.
- Simultaneous drain/reload: lane 0 valid, ready_out[0]=1, ptr=0, valid_in with 8'h5A -> next cycle data_out lane 0=8'h5A and valid_out[0]=1 with no bubble.
- Explicit mode, NUM_OUT=3, MODE=1: sel_in=2, data 8'h33 -> lane 2 only. Then sel_in=3 with valid_in=1 -> ready_in=0, err_sel pulses 1 cycle, no lane changes.
- Reset mid-operation: both lanes full and stalled, assert reset for 1 cycle -> next cycle valid_out=0, ptr_out=0; the held words are never presented.
